// File: rtl/rect_fill_engine_if.sv
// Command and RAM-write bundle for the rectangle fill engine.
// The master side issues fill commands and observes the pixel write stream.
// The slave side (the engine) accepts commands and drives the write port.
interface rect_fill_engine_if #(
  parameter int ADD_WIDTH  = 8,
  parameter int DATA_WIDTH = 3
);
  logic                  iStart;
  logic [ADD_WIDTH-1:0]  iRow;
  logic [ADD_WIDTH-1:0]  iCol;
  logic [ADD_WIDTH-1:0]  iHeight;
  logic [ADD_WIDTH-1:0]  iWidth;
  logic [DATA_WIDTH-1:0] iColor;
  logic                  oBusy;
  logic                  oDone;
  logic                  oWriteEnable;
  logic [ADD_WIDTH-1:0]  oWriteRow;
  logic [ADD_WIDTH-1:0]  oWriteCol;
  logic [DATA_WIDTH-1:0] oRGB;

  modport master (
    output iStart, iRow, iCol, iHeight, iWidth, iColor,
    input  oBusy, oDone, oWriteEnable, oWriteRow, oWriteCol, oRGB
  );

  modport slave (
    input  iStart, iRow, iCol, iHeight, iWidth, iColor,
    output oBusy, oDone, oWriteEnable, oWriteRow, oWriteCol, oRGB
  );
endinterface

// File: rtl/rect_fill_engine.sv
// Rectangle fill sequencer feeding the frame RAM write port.
// One command per start strobe; emits one clipped pixel write per cycle in
// raster order and then a single-cycle done pulse. The write-port registers
// double as the raster cursor, so the first pixel appears in the cycle right
// after the command is taken.
module rect_fill_engine #(
  parameter int ADD_WIDTH  = 8,
  parameter int DATA_WIDTH = 3,
  parameter int ROW_MAX    = 255,
  parameter int COL_MAX    = 255
) (
  input logic              Clock,
  input logic              Reset,
  rect_fill_engine_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [ADD_WIDTH:0] ROW_LIM = (ADD_WIDTH+1)'(ROW_MAX);
  localparam logic [ADD_WIDTH:0] COL_LIM = (ADD_WIDTH+1)'(COL_MAX);

  logic [1:0]            state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  we_q, we_d;
  logic [ADD_WIDTH-1:0]  row_q, row_d;
  logic [ADD_WIDTH-1:0]  col_q, col_d;
  logic [DATA_WIDTH-1:0] rgb_q, rgb_d;
  logic [ADD_WIDTH-1:0]  startCol_q, startCol_d;
  logic [ADD_WIDTH-1:0]  rowEnd_q, rowEnd_d;
  logic [ADD_WIDTH-1:0]  colEnd_q, colEnd_d;

  // One extra bit keeps origin+size-1 from wrapping before it is clipped.
  logic [ADD_WIDTH:0] rowSum;
  logic [ADD_WIDTH:0] colSum;
  logic               isEmpty;

  assign rowSum = {1'b0, bus.iRow} + {1'b0, bus.iHeight} - 1'b1;
  assign colSum = {1'b0, bus.iCol} + {1'b0, bus.iWidth} - 1'b1;

  assign isEmpty = (bus.iHeight == '0) || (bus.iWidth == '0) ||
                   ({1'b0, bus.iRow} > ROW_LIM) || ({1'b0, bus.iCol} > COL_LIM);

  // Next-state logic: command accept, raster stepping and completion.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    we_d       = we_q;
    row_d      = row_q;
    col_d      = col_q;
    rgb_d      = rgb_q;
    startCol_d = startCol_q;
    rowEnd_d   = rowEnd_q;
    colEnd_d   = colEnd_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        we_d   = 1'b0;
        if (bus.iStart) begin
          startCol_d = bus.iCol;
          rowEnd_d   = (rowSum > ROW_LIM) ? ROW_LIM[ADD_WIDTH-1:0] : rowSum[ADD_WIDTH-1:0];
          colEnd_d   = (colSum > COL_LIM) ? COL_LIM[ADD_WIDTH-1:0] : colSum[ADD_WIDTH-1:0];
          busy_d     = 1'b1;
          if (isEmpty) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = FILL;
            we_d    = 1'b1;
            row_d   = bus.iRow;
            col_d   = bus.iCol;
            rgb_d   = bus.iColor;
          end
        end
      end

      FILL: begin
        if ((row_q == rowEnd_q) && (col_q == colEnd_q)) begin
          state_d = DONE;
          we_d    = 1'b0;
          done_d  = 1'b1;
        end else if (col_q == colEnd_q) begin
          col_d = startCol_q;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything and drops any fill.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      rgb_q      <= '0;
      startCol_q <= '0;
      rowEnd_q   <= '0;
      colEnd_q   <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      we_q       <= we_d;
      row_q      <= row_d;
      col_q      <= col_d;
      rgb_q      <= rgb_d;
      startCol_q <= startCol_d;
      rowEnd_q   <= rowEnd_d;
      colEnd_q   <= colEnd_d;
    end
  end

  assign bus.oBusy        = busy_q;
  assign bus.oDone        = done_q;
  assign bus.oWriteEnable = we_q;
  assign bus.oWriteRow    = row_q;
  assign bus.oWriteCol    = col_q;
  assign bus.oRGB         = rgb_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine: a frame-bound model pushes the
// expected write stream (with its cycle) and done pulses into queues; a
// monitor pops and compares them as the engine produces output.
module tb_rect_fill_engine;

  localparam int TB_ROW_MAX = 255;
  localparam int TB_COL_MAX = 255;

  typedef struct {
    int cyc;
    int row;
    int col;
    int rgb;
  } wrExp_t;

  logic Clock;
  logic Reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  wrExp_t expQ[$];
  int     doneQ[$];

  rect_fill_engine_if #(.ADD_WIDTH(8), .DATA_WIDTH(3)) bus ();

  rect_fill_engine #(
    .ADD_WIDTH (8),
    .DATA_WIDTH(3),
    .ROW_MAX   (TB_ROW_MAX),
    .COL_MAX   (TB_COL_MAX)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  // Free-running clock and a cycle counter used to time-stamp expectations.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: raster walk with frame clipping, consecutive write cycles.
  task automatic pushExpected(input int row, input int col, input int h, input int w,
                              input int color, input int base, input int maxWrites);
    int t;
    int n;
    int inBounds;
    wrExp_t e;
    t = base;
    n = 0;
    inBounds = 0;
    for (int r = row; r < row + h; r++) begin
      for (int c = col; c < col + w; c++) begin
        if (r <= TB_ROW_MAX && c <= TB_COL_MAX) begin
          inBounds++;
          if (n < maxWrites) begin
            e.cyc = t;
            e.row = r;
            e.col = c;
            e.rgb = color;
            expQ.push_back(e);
            t++;
            n++;
          end
        end
      end
    end
    if (inBounds <= maxWrites) doneQ.push_back(t);
  endtask

  task automatic applyStimulus(input int row, input int col, input int h, input int w,
                               input int color, input int maxWrites);
    @(negedge Clock);
    bus.iStart  = 1'b1;
    bus.iRow    = 8'(row);
    bus.iCol    = 8'(col);
    bus.iHeight = 8'(h);
    bus.iWidth  = 8'(w);
    bus.iColor  = 3'(color);
    pushExpected(row, col, h, w, color, cyc + 1, maxWrites);
    @(negedge Clock);
    bus.iStart = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    bit finished;
    finished = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clock);
      #1;
      if (expQ.size() == 0 && doneQ.size() == 0) begin
        finished = 1'b1;
        break;
      end
    end
    if (!finished) begin
      checkOutput("timeout", 0, 1);
      expQ.delete();
      doneQ.delete();
    end
  endtask

  // Scoreboard monitor: every write and done pulse must match the queue head.
  always @(negedge Clock) begin : monitor
    wrExp_t e;
    int d;
    if (bus.oWriteEnable === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("extraWrite", 1, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("wrCycle", cyc, e.cyc);
        checkOutput("wrRow", int'(bus.oWriteRow), e.row);
        checkOutput("wrCol", int'(bus.oWriteCol), e.col);
        checkOutput("wrRgb", int'(bus.oRGB), e.rgb);
        checkOutput("wrBusy", int'(bus.oBusy), 1);
      end
    end
    if (bus.oDone === 1'b1) begin
      if (doneQ.size() == 0) begin
        checkOutput("extraDone", 1, 0);
      end else begin
        d = doneQ.pop_front();
        checkOutput("doneCycle", cyc, d);
        checkOutput("doneBusy", int'(bus.oBusy), 1);
        checkOutput("doneWe", int'(bus.oWriteEnable), 0);
      end
    end
  end

  // Directed scenarios followed by a few random commands.
  initial begin
    int k;
    Reset       = 1'b1;
    bus.iStart  = 1'b0;
    bus.iRow    = '0;
    bus.iCol    = '0;
    bus.iHeight = '0;
    bus.iWidth  = '0;
    bus.iColor  = '0;

    repeat (3) @(negedge Clock);
    checkOutput("rstBusy", int'(bus.oBusy), 0);
    checkOutput("rstDone", int'(bus.oDone), 0);
    checkOutput("rstWe", int'(bus.oWriteEnable), 0);
    checkOutput("rstRow", int'(bus.oWriteRow), 0);
    checkOutput("rstCol", int'(bus.oWriteCol), 0);
    checkOutput("rstRgb", int'(bus.oRGB), 0);
    Reset = 1'b0;

    $display("[TB] basic 2x3 fill");
    applyStimulus(10, 20, 2, 3, 5, 1000);
    waitDone(40);
    @(negedge Clock);
    checkOutput("idleBusy1", int'(bus.oBusy), 0);

    $display("[TB] empty width");
    applyStimulus(30, 40, 4, 0, 2, 1000);
    waitDone(10);
    @(negedge Clock);
    checkOutput("idleBusy2", int'(bus.oBusy), 0);

    $display("[TB] column clipping");
    applyStimulus(0, 254, 2, 4, 3, 1000);
    waitDone(40);

    $display("[TB] start ignored during fill");
    applyStimulus(100, 10, 1, 8, 6, 1000);
    @(negedge Clock);
    @(negedge Clock);
    bus.iStart  = 1'b1;
    bus.iRow    = 8'd7;
    bus.iCol    = 8'd9;
    bus.iHeight = 8'd3;
    bus.iWidth  = 8'd3;
    bus.iColor  = 3'd1;
    @(negedge Clock);
    bus.iStart = 1'b0;
    waitDone(40);

    $display("[TB] reset during fill");
    applyStimulus(20, 30, 4, 4, 4, 3);
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    checkOutput("rstMidWe", int'(bus.oWriteEnable), 0);
    checkOutput("rstMidDone", int'(bus.oDone), 0);
    checkOutput("rstMidBusy", int'(bus.oBusy), 0);
    checkOutput("rstMidPending", expQ.size(), 0);
    applyStimulus(5, 5, 2, 2, 7, 1000);
    waitDone(40);

    $display("[TB] start held through done");
    @(negedge Clock);
    bus.iStart  = 1'b1;
    bus.iRow    = 8'd50;
    bus.iCol    = 8'd60;
    bus.iHeight = 8'd1;
    bus.iWidth  = 8'd2;
    bus.iColor  = 3'd6;
    k = cyc;
    pushExpected(50, 60, 1, 2, 6, k + 1, 1000);
    pushExpected(50, 60, 1, 2, 6, k + 5, 1000);
    repeat (5) @(negedge Clock);
    bus.iStart = 1'b0;
    waitDone(40);

    $display("[TB] random commands");
    for (int i = 0; i < 6; i++) begin
      applyStimulus((i % 2 == 0) ? int'($urandom_range(250, 255)) : int'($urandom_range(0, 255)),
                    int'($urandom_range(240, 255)),
                    int'($urandom_range(0, 6)),
                    int'($urandom_range(0, 6)),
                    int'($urandom_range(0, 7)),
                    1000);
      waitDone(80);
    end

    repeat (3) @(negedge Clock);
    checkOutput("leftWrites", expQ.size(), 0);
    checkOutput("leftDone", doneQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
